// File: rtl/lsu_mem_ctrl.sv
// Load/store unit in front of a sync-write / async-read data RAM.
// Sub-word stores are done as read-modify-write; loads are lane-extracted and extended.
module lsu_mem_ctrl #(
    parameter int DATA = 32,
    parameter int ADD  = 10
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [31:0]     req_addr,
    input  logic [31:0]     req_wdata,
    output logic            resp_valid,
    output logic            resp_err,
    output logic [31:0]     resp_rdata,
    output logic [ADD-1:0]  ram_address,
    output logic [DATA-1:0] ram_data_in,
    output logic            ram_wren,
    input  logic [DATA-1:0] ram_data_out
);

    // state  | meaning
    // IDLE   | ready for a request
    // ACCESS | RAM addressed; load capture, word write, or old-word read (idle slot for rejected requests)
    // MERGE  | write old word with new lane(s)
    // RESP   | one-cycle good response
    // ERR    | one-cycle error response, nothing written
    typedef enum logic [2:0] {IDLE, ACCESS, MERGE, RESP, ERR} state_t;

    state_t      state, state_nxt;
    logic        we_q, uns_q, err_q;
    logic [1:0]  size_q, lane_q;
    logic [31:0] rdata_q;
    logic [31:0] load_val, merged;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        accept, req_err;
    logic        addr_unused;

    assign addr_unused = &{1'b0, req_addr[31:ADD+2]};

    assign accept  = (state == IDLE) && req_valid;
    assign req_err = (req_size == 2'b11)
                   || ((req_size == 2'b01) && req_addr[0])
                   || ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = ACCESS;
            ACCESS: begin
                if (err_q)                          state_nxt = ERR;
                else if (we_q && size_q != 2'b10)   state_nxt = MERGE;
                else                                state_nxt = RESP;
            end
            MERGE:   state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state == IDLE);
        resp_valid = (state == RESP) || (state == ERR);
        resp_err   = (state == ERR);
        ram_wren   = 1'b1;
        if (!reset) begin
            if ((state == ACCESS && we_q && size_q == 2'b10 && !err_q) || state == MERGE)
                ram_wren = 1'b0;
        end
    end

    assign resp_rdata = rdata_q;

    always_comb begin
        byte_sel = ram_data_out[{lane_q, 3'b000} +: 8];
        half_sel = ram_data_out[{lane_q[1], 4'b0000} +: 16];
        case (size_q)
            2'b00:   load_val = uns_q ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            2'b01:   load_val = uns_q ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: load_val = ram_data_out;
        endcase
    end

    // ram_data_in still holds the right-aligned store data when the old word arrives
    always_comb begin
        merged = ram_data_out;
        case (size_q)
            2'b00:   merged[{lane_q, 3'b000} +: 8]     = ram_data_in[7:0];
            2'b01:   merged[{lane_q[1], 4'b0000} +: 16] = ram_data_in[15:0];
            default: merged = ram_data_in;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            we_q        <= 1'b0;
            uns_q       <= 1'b0;
            err_q       <= 1'b0;
            size_q      <= 2'b00;
            lane_q      <= 2'b00;
            rdata_q     <= 32'h0;
            ram_address <= '0;
            ram_data_in <= '0;
        end else if (accept) begin
            we_q        <= req_we;
            uns_q       <= req_unsigned;
            err_q       <= req_err;
            size_q      <= req_size;
            lane_q      <= req_addr[1:0];
            rdata_q     <= 32'h0;
            ram_address <= req_addr[ADD+1:2];
            ram_data_in <= req_wdata;
        end else if (state == ACCESS && !err_q) begin
            if (!we_q)
                rdata_q <= load_val;
            else if (size_q != 2'b10)
                ram_data_in <= merged;
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scoreboard bench for lsu_mem_ctrl with a behavioural RAM attached.
module tb_lsu_mem_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
    logic        req_ready, resp_valid, resp_err, ram_wren;
    logic [31:0] resp_rdata;
    logic [9:0]  ram_address;
    logic [31:0] ram_data_in, ram_data_out;

    int total = 0, bad = 0;
    int cyc = 0;
    int write_cnt = 0, exp_writes = 0;
    logic [32:0] exp_q[$];
    int          resp_t[$];
    logic [31:0] ram[1024];
    logic [31:0] ref_mem[1024];

    lsu_mem_ctrl #(.DATA(32), .ADD(10)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err),
        .resp_rdata(resp_rdata), .ram_address(ram_address), .ram_data_in(ram_data_in),
        .ram_wren(ram_wren), .ram_data_out(ram_data_out)
    );

    always #5 clock = ~clock;

    assign ram_data_out = ram[ram_address];
    always @(posedge clock) begin
        if (!ram_wren) ram[ram_address] <= ram_data_in;
        cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clock) begin
        if (!reset && !ram_wren) write_cnt++;
        if (!reset && resp_valid) begin
            resp_t.push_back(cyc);
            if (exp_q.size() == 0) chk("unexpected_resp", 1, 0);
            else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                chk("resp_err", {31'h0, resp_err}, {31'h0, e[32]});
                chk("resp_rdata", resp_rdata, e[31:0]);
            end
        end
    end

    function automatic logic [31:0] model_store(input logic [31:0] old, input logic [1:0] size,
                                                input logic [1:0] lane, input logic [31:0] wd);
        logic [31:0] mask;
        case (size)
            2'b00: begin mask = 32'hFF << (8 * lane);
                         return (old & ~mask) | ((wd & 32'hFF) << (8 * lane)); end
            2'b01: begin mask = 32'hFFFF << (16 * lane[1]);
                         return (old & ~mask) | ((wd & 32'hFFFF) << (16 * lane[1])); end
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] size,
                                               input logic [1:0] lane, input logic uns);
        logic [31:0] s;
        case (size)
            2'b00: begin s = (w >> (8 * lane)) & 32'hFF;
                         if (!uns && s[7]) s = s | 32'hFFFFFF00; return s; end
            2'b01: begin s = (w >> (16 * lane[1])) & 32'hFFFF;
                         if (!uns && s[15]) s = s | 32'hFFFF0000; return s; end
            default: return w;
        endcase
    endfunction

    // expected response and latency for a request accepted now; updates the reference memory
    task automatic model_issue(input logic we, input logic [1:0] size, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wd, output int lat);
        logic err;
        logic [9:0] w;
        err = (size == 2'b11) || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
        w = addr[11:2];
        lat = 2;
        if (err) exp_q.push_back({1'b1, 32'h0});
        else if (we) begin
            ref_mem[w] = model_store(ref_mem[w], size, addr[1:0], wd);
            exp_writes++;
            exp_q.push_back({1'b0, 32'h0});
            if (size != 2'b10) lat = 3;
        end else exp_q.push_back({1'b0, model_load(ref_mem[w], size, addr[1:0], uns)});
    endtask

    task automatic drive(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
    endtask

    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd);
        int n, lat;
        n = 0;
        @(negedge clock);
        while (!req_ready && n < 10) begin @(negedge clock); n++; end
        if (!req_ready) chk("ready_timeout", 0, 1);
        drive(we, size, uns, addr, wd);
        model_issue(we, size, uns, addr, wd, lat);
        @(posedge clock);
        #1 req_valid = 1'b0;
        n = 0;
        do begin @(negedge clock); n++; end while (!resp_valid && n < 8);
        chk("latency", n, lat);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        int acc, lat, n, wc;
        for (int i = 0; i < 1024; i++) begin ram[i] = 32'h0; ref_mem[i] = 32'h0; end
        repeat (3) @(negedge clock);
        chk("reset_wren", ram_wren, 1);
        reset = 1'b0;
        #1;
        chk("reset_ready", req_ready, 1);
        chk("reset_resp_valid", resp_valid, 0);
        chk("reset_resp_err", resp_err, 0);
        chk("reset_rdata", resp_rdata, 0);
        chk("reset_ram_address", {22'h0, ram_address}, 0);
        chk("reset_ram_data_in", ram_data_in, 0);
        chk("reset_ram_wren", ram_wren, 1);

        // word store / load, wrapped address aliasing the same word
        do_req(1, 2'b10, 0, 32'h10, 32'hDEADBEEF);
        chk("ram_word4_sw", ram[4], 32'hDEADBEEF);
        do_req(0, 2'b10, 0, 32'h10, 0);
        do_req(0, 2'b10, 1, 32'hFFFF_F010, 0);

        // byte RMW and byte loads
        do_req(1, 2'b10, 0, 32'h10, 32'h11223344);
        do_req(1, 2'b00, 0, 32'h11, 32'h123456AA);
        chk("ram_word4_sb", ram[4], 32'h1122AA44);
        do_req(0, 2'b00, 0, 32'h11, 0);
        do_req(0, 2'b00, 1, 32'h11, 0);
        do_req(0, 2'b00, 0, 32'h10, 0);

        // half RMW and half loads
        do_req(1, 2'b01, 0, 32'h12, 32'hFFFF8001);
        chk("ram_word4_sh", ram[4], 32'h8001AA44);
        do_req(0, 2'b01, 0, 32'h12, 0);
        do_req(0, 2'b01, 1, 32'h12, 0);
        do_req(0, 2'b01, 0, 32'h10, 0);

        // errors: no RAM writes
        wc = write_cnt;
        do_req(0, 2'b10, 0, 32'h13, 0);
        do_req(1, 2'b01, 0, 32'h11, 32'h5555);
        do_req(1, 2'b11, 0, 32'h10, 32'h7777);
        chk("err_no_write", write_cnt, wc);
        chk("ram_word4_after_err", ram[4], 32'h8001AA44);

        // reset during MERGE of a byte store
        @(negedge clock);
        wc = write_cnt;
        drive(1, 2'b00, 0, 32'h10, 32'h55);
        @(posedge clock);
        #1 req_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1 chk("midop_reset_wren", ram_wren, 1);
        @(negedge clock);
        chk("midop_reset_wren2", ram_wren, 1);
        reset = 1'b0;
        #1 chk("ready_after_reset", req_ready, 1);
        repeat (4) @(negedge clock);
        chk("midop_no_write", write_cnt, wc);
        chk("midop_word_kept", ram[4], 32'h8001AA44);
        do_req(0, 2'b10, 0, 32'h10, 0);

        // req_valid held high, SB/LW alternating
        @(negedge clock);
        resp_t.delete();
        acc = 0;
        for (int c = 0; c < 10; c++) begin
            if (acc % 2 == 0) drive(1, 2'b00, 0, 32'h40 + acc / 2, 32'hA0 + acc);
            else              drive(0, 2'b10, 0, 32'h40, 0);
            if (req_ready) begin
                model_issue(req_we, req_size, req_unsigned, req_addr, req_wdata, lat);
                acc++;
            end
            @(negedge clock);
        end
        req_valid = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin @(negedge clock); n++; end
        chk("held_accepts", acc, 3);
        chk("held_resp_count", resp_t.size(), 3);
        if (resp_t.size() == 3) begin
            chk("held_gap0", resp_t[1] - resp_t[0], 3);
            chk("held_gap1", resp_t[2] - resp_t[1], 4);
        end
        do_req(0, 2'b10, 0, 32'h40, 0);

        repeat (2) @(negedge clock);
        chk("total_writes", write_cnt, exp_writes);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
